// File: rtl/calc_engine_mux.sv
// Multi-cycle calculator: debounced operand/op buttons, add/sub/mul/fixed-point divide,
// iterative double-dabble to BCD and a scanned active-low 7-segment display.

module calc_debounce #(
    parameter int CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Count saturates at CYCLES so a held button fires exactly once until released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1]) begin
                cnt <= '0;
            end else if (cnt != CW'(CYCLES)) begin
                cnt   <= cnt + 1'b1;
                press <= (cnt == CW'(CYCLES - 1));
            end
        end
    end
endmodule

module calc_engine_mux #(
    parameter int IN_WIDTH        = 4,
    parameter int NUM_DIGITS      = 4,
    parameter int FRAC_DIGITS     = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REFRESH_CYCLES  = 50000,
    parameter int HOLD_RESULT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_WIDTH-1:0]   in_number,
    input  logic [1:0]            key,
    input  logic [3:0]            arif,
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [7:0]            segments,
    output logic [2:0]            led,
    output logic                  busy
);
    localparam int MAG_W   = 2 * IN_WIDTH + 4 * FRAC_DIGITS;
    localparam int BCD_DIG = (MAG_W + 2) / 3;
    localparam int PAD_DIG = (BCD_DIG > NUM_DIGITS) ? BCD_DIG : NUM_DIGITS;
    localparam int CNT_W   = $clog2(MAG_W + 1);
    localparam int REF_W   = $clog2(REFRESH_CYCLES + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam bit DP_OK   = (FRAC_DIGITS > 0) && (FRAC_DIGITS < NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAG_W - 1);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam logic [MAG_W-1:0] SCALE = MAG_W'(pow10(FRAC_DIGITS));

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    typedef enum logic [2:0] {ENTRY, CALC, DIV, BCD, RESULT} state_t;

    // Button events: [1:0] keys, [5:2] ops
    logic [5:0] btn_all;
    logic [5:0] ev;
    assign btn_all = {arif, key};

    for (genvar gi = 0; gi < 6; gi++) begin : g_db
        calc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_all[gi]),
            .press (ev[gi])
        );
    end

    logic       key_ev;
    logic       op_ev;
    logic [1:0] op_sel;
    assign key_ev = |ev[1:0];

    always_comb begin
        op_ev  = |ev[5:2];
        op_sel = 2'd0;
        for (int i = 3; i >= 0; i--) if (ev[2+i]) op_sel = 2'(i);
    end

    state_t                          state;
    logic [IN_WIDTH-1:0]             a, b, src, live;
    logic [1:0]                      op;
    logic                            neg, err, conv_run;
    logic [MAG_W-1:0]                q, bin_sr;
    logic [IN_WIDTH-1:0]             r;
    logic [4*BCD_DIG-1:0]            bcd_sr, bcd_adj, bcd_next;
    logic [4*PAD_DIG-1:0]            bcd_pad;
    logic [CNT_W-1:0]                cnt;
    logic [NUM_DIGITS-1:0][3:0]      disp_dig;
    logic                            disp_neg, disp_err, disp_dp;

    assign live = ~in_number;

    // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < BCD_DIG; i++)
            if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    assign bcd_next = {bcd_adj[4*BCD_DIG-2:0], bin_sr[MAG_W-1]};
    assign bcd_pad  = (4*PAD_DIG)'(bcd_next);

    // Overflow means a nonzero digit beyond what the display can hold
    logic ovf_pos, ovf_neg;
    always_comb begin
        ovf_pos = 1'b0;
        ovf_neg = 1'b0;
        for (int i = 0; i < BCD_DIG; i++) begin
            if (bcd_next[4*i +: 4] != 4'd0) begin
                if (i >= NUM_DIGITS)     ovf_pos = 1'b1;
                if (i >= NUM_DIGITS - 1) ovf_neg = 1'b1;
            end
        end
    end

    // Sign-magnitude result; for divide this is the scaled dividend
    logic [MAG_W-1:0] calc_mag;
    logic             calc_neg;
    always_comb begin
        calc_mag = '0;
        calc_neg = 1'b0;
        case (op)
            2'd0: calc_mag = MAG_W'(a) + MAG_W'(b);
            2'd1: begin
                if (a >= b) begin
                    calc_mag = MAG_W'(a - b);
                end else begin
                    calc_mag = MAG_W'(b - a);
                    calc_neg = 1'b1;
                end
            end
            2'd2:    calc_mag = MAG_W'(a) * MAG_W'(b);
            default: calc_mag = MAG_W'(a) * SCALE;
        endcase
    end

    logic [IN_WIDTH:0] div_try;
    logic              div_ge;
    assign div_try = {r, q[MAG_W-1]};
    assign div_ge  = (div_try >= {1'b0, b});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ENTRY;
            a        <= '0;
            b        <= '0;
            src      <= '0;
            op       <= 2'd0;
            led      <= 3'b110;
            busy     <= 1'b0;
            neg      <= 1'b0;
            err      <= 1'b0;
            conv_run <= 1'b0;
            q        <= '0;
            r        <= '0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            cnt      <= '0;
            disp_dig <= '0;
            disp_neg <= 1'b0;
            disp_err <= 1'b0;
            disp_dp  <= 1'b0;
        end else begin
            case (state)
                ENTRY, RESULT: begin
                    if (key_ev) begin
                        if (ev[0]) begin a <= live; led <= 3'b101; end
                        if (ev[1]) begin b <= live; led <= 3'b011; end
                        state    <= ENTRY;
                        conv_run <= 1'b0;
                    end else if (op_ev) begin
                        op       <= op_sel;
                        led      <= 3'b110;
                        busy     <= 1'b1;
                        state    <= CALC;
                        conv_run <= 1'b0;
                    end else if (state == RESULT) begin
                        if (HOLD_RESULT == 0 && arif[op]) state <= ENTRY;
                    end else if (!conv_run || live != src) begin
                        // A switch change restarts the live conversion immediately
                        src      <= live;
                        bin_sr   <= MAG_W'(live);
                        bcd_sr   <= '0;
                        cnt      <= '0;
                        conv_run <= 1'b1;
                    end else begin
                        bin_sr <= bin_sr << 1;
                        bcd_sr <= bcd_next;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            conv_run <= 1'b0;
                            disp_neg <= 1'b0;
                            disp_err <= 1'b0;
                            disp_dp  <= 1'b0;
                            for (int i = 0; i < NUM_DIGITS; i++) disp_dig[i] <= bcd_pad[4*i +: 4];
                        end
                    end
                end
                CALC: begin
                    neg <= calc_neg;
                    err <= 1'b0;
                    cnt <= '0;
                    if (op == 2'd3 && b == '0) begin
                        err    <= 1'b1;
                        bin_sr <= '0;
                        bcd_sr <= '0;
                        state  <= BCD;
                    end else if (op == 2'd3) begin
                        q     <= calc_mag;
                        r     <= '0;
                        state <= DIV;
                    end else begin
                        bin_sr <= calc_mag;
                        bcd_sr <= '0;
                        state  <= BCD;
                    end
                end
                DIV: begin
                    q   <= {q[MAG_W-2:0], div_ge};
                    r   <= div_ge ? IN_WIDTH'(div_try - {1'b0, b}) : div_try[IN_WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bin_sr <= {q[MAG_W-2:0], div_ge};
                        bcd_sr <= '0;
                        cnt    <= '0;
                        state  <= BCD;
                    end
                end
                BCD: begin
                    bin_sr <= bin_sr << 1;
                    bcd_sr <= bcd_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= RESULT;
                        busy     <= 1'b0;
                        disp_err <= err | (neg ? ovf_neg : ovf_pos);
                        disp_neg <= neg;
                        disp_dp  <= (op == 2'd3);
                        for (int i = 0; i < NUM_DIGITS; i++) disp_dig[i] <= bcd_pad[4*i +: 4];
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

    // Digit scan; anodes and segments share one register stage so they always agree
    logic [REF_W-1:0] ref_cnt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       seg_cur;

    always_comb begin
        seg_cur = seg7(disp_dig[idx]);
        if (disp_err)
            seg_cur = (idx == '0) ? 8'h86 : 8'hC0;
        else if (disp_neg && idx == IDX_W'(NUM_DIGITS - 1))
            seg_cur = 8'hBF;
        else if (DP_OK && disp_dp && idx == IDX_W'(FRAC_DIGITS))
            seg_cur[7] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            idx      <= '0;
            anodes   <= '1;
            segments <= 8'hFF;
        end else begin
            if (ref_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
                ref_cnt <= '0;
                idx     <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            anodes   <= ~(NUM_DIGITS'(1) << idx);
            segments <= seg_cur;
        end
    end
endmodule
